// File: rtl/gray_pkg.sv
// Shared definitions for the Gray decode/step checker.
//   GRAY_WIDTH : default width of the Gray input and binary output words
//   dir_t      : step class reported with every decoded word
package gray_pkg;

    localparam int GRAY_WIDTH = 8;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        ERR  = 2'b11
    } dir_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder.
//   WIDTH : word width
//   i_g   : Gray-coded input word
//   o_b   : binary word, o_b[i] = XOR of i_g[WIDTH-1:i]
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] i_g,
    output logic [WIDTH-1:0] o_b
);

    // Each binary bit is the reduction XOR of all Gray bits at or above it,
    // which is the closed form of the MSB-down running XOR.
    always_comb begin
        o_b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_b[i] = ^(i_g >> i);
        end
    end

endmodule

// File: rtl/gray_decode_checker.sv
// Two-stage Gray decoder with step checker.
// S1 captures the Gray word; the decoder sits between S1 and S2; S2 holds
// the binary word with its step class relative to the previous S2 word.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid/in_ready/G      : upstream Gray word handshake
//   clear      : synchronous clear of step history and error count
//   out_valid/out_ready      : downstream handshake for B/dir/step_err
//   B          : decoded binary word
//   dir        : 00 HOLD, 01 UP, 10 DOWN, 11 ERR
//   step_err   : word is not a legal step from its predecessor
//   err_cnt    : saturating count of step errors
module gray_decode_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] G,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       dir,
    output logic             step_err,
    output logic [7:0]       err_cnt
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_g;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_b;
    dir_t             r_dir;
    logic             r_step_err;
    logic [WIDTH-1:0] r_bprev;
    logic             r_have_prev;
    logic [7:0]       r_err_cnt;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_diff;
    logic             w_first;
    dir_t             w_dir;

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    // in_ready depends only on pipeline state and out_ready, never on
    // in_valid; rst_n gating keeps it low while reset is held.
    assign in_ready  = rst_n & (~r_s1_valid | w_s2_load);
    assign w_s1_load = in_valid & in_ready;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .i_g (r_s1_g),
        .o_b (w_b)
    );

    assign w_diff  = w_b - r_bprev;
    // A clear coinciding with an S2 load makes that word a first word.
    assign w_first = ~r_have_prev | clear;

    always_comb begin
        w_dir = HOLD;
        if (!w_first) begin
            if (w_diff == '0)                w_dir = HOLD;
            else if (w_diff == WIDTH'(1))    w_dir = UP;
            else if (w_diff == '1)           w_dir = DOWN;
            else                             w_dir = ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_g     <= G;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_b        <= '0;
            r_dir      <= HOLD;
            r_step_err <= 1'b0;
            r_bprev    <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_b        <= w_b;
                r_dir      <= w_dir;
                r_step_err <= (w_dir == ERR);
                r_bprev    <= w_b;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have_prev <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_s2_load)  r_have_prev <= 1'b1;
            else if (clear) r_have_prev <= 1'b0;

            if (clear)
                r_err_cnt <= '0;
            else if (w_s2_load && (w_dir == ERR) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign B         = r_b;
    assign dir       = r_dir;
    assign step_err  = r_step_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_decode_checker.sv
module tb_gray_decode_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] G;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] B;
    logic [1:0]   dir;
    logic         step_err;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    gray_decode_checker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .G         (G),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .B         (B),
        .dir       (dir),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        int b;
        int d;
        int e;
        int c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   m_prev = 0;
    bit   m_have = 0;
    int   m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc(input int n);
        return (n ^ (n >> 1)) & 255;
    endfunction

    // Inverse of the Gray encoding by exhaustive search.
    function automatic int dec(input int g);
        for (int n = 0; n < 256; n++)
            if (enc(n) == g) return n;
        return -1;
    endfunction

    task automatic model_accept(input int g);
        exp_t e;
        int   b;
        int   d;
        b = dec(g);
        if (!m_have) e.d = 0;
        else begin
            d = (b - m_prev + 256) % 256;
            e.d = (d == 0) ? 0 : (d == 1) ? 1 : (d == 255) ? 2 : 3;
        end
        e.e = (e.d == 3) ? 1 : 0;
        if (e.e == 1 && m_cnt < 255) m_cnt++;
        e.b = b;
        e.c = m_cnt;
        m_prev = b;
        m_have = 1;
        q.push_back(e);
    endtask

    task automatic cyc(input bit iv, input int g, input bit ordy, input bit clr, output bit acc);
        exp_t e;
        in_valid  = iv;
        G         = g[W-1:0];
        out_ready = ordy;
        clear     = clr;
        #1;
        acc = iv && in_ready;
        if (out_valid && ordy) begin
            n_out++;
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("out_B", B, e.b);
                chk("out_dir", dir, e.d);
                chk("out_step_err", step_err, e.e);
                chk("out_err_cnt", err_cnt, e.c);
            end
        end
        if (acc) model_accept(g);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc(0, 0, 1, 0, a);
        chk("drain_empty", q.size(), 0);
        chk("drain_ov", out_valid, 0);
    endtask

    task automatic send(input int g);
        bit a;
        a = 0;
        for (int i = 0; i < 20 && !a; i++) cyc(1, g, 1, 0, a);
        if (!a) chk("send_timeout", a, 1);
    endtask

    task automatic do_clear();
        bit a;
        cyc(0, 0, 1, 1, a);
        m_have = 0;
        m_cnt  = 0;
        chk("clear_err_cnt", err_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int idx;
        int n;
        int base;

        rst_n = 0; in_valid = 0; G = '0; clear = 0; out_ready = 0;
        @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_B", B, 0);
        chk("rst_dir", dir, 0);
        chk("rst_step_err", step_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1; #1;
        chk("rel_in_ready", in_ready, 1);

        // Latency and reference vector
        cyc(1, 'hE6, 1, 0, a);
        chk("lat_acc", a, 1);
        chk("lat_ov1", out_valid, 0);
        cyc(0, 0, 0, 0, a);
        chk("lat_ov2", out_valid, 1);
        chk("vec_B", B, 'hBB);
        chk("vec_dir", dir, 0);
        chk("vec_step_err", step_err, 0);
        drain();

        // Counting stream 0..5
        do_clear();
        for (int k = 0; k < 6; k++) send(enc(k));
        drain();
        chk("cnt_B_last", B, 5);
        chk("cnt_err_cnt", err_cnt, 0);

        // Wrap in both directions
        do_clear();
        send('h80); send('h00); send('h80);
        drain();
        chk("wrap_dir_down", dir, 2);
        chk("wrap_B", B, 255);
        chk("wrap_err_cnt", err_cnt, 0);

        // Illegal jump
        do_clear();
        send('h02); send('h04);
        drain();
        chk("jump_B", B, 7);
        chk("jump_dir", dir, 3);
        chk("jump_step_err", step_err, 1);
        chk("jump_err_cnt", err_cnt, 1);

        // Saturation
        for (int k = 0; k < 300; k++) send((k % 2) ? 'hC0 : 'h00);
        drain();
        chk("sat_err_cnt", err_cnt, 255);

        // Backpressure: 3 words offered, 4 stalled cycles
        do_clear();
        base = n_out;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(idx < 3, enc(10 + idx), 0, 0, a);
            if (a) idx++;
            if (k >= 2) begin
                chk("bp_hold_ov", out_valid, 1);
                chk("bp_hold_B", B, 10);
            end
        end
        chk("bp_stored", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 20 && (idx < 3 || q.size() > 0); k++) begin
            cyc(idx < 3, enc(10 + idx), 1, 0, a);
            if (a) idx++;
        end
        chk("bp_all_sent", idx, 3);
        chk("bp_out_count", n_out - base, 3);
        drain();

        // Randomised traffic
        n = 0;
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      n = n;
            else if (r < 6) n = (n + 1) % 256;
            else if (r < 8) n = (n + 255) % 256;
            else            n = $urandom_range(0, 255);
            cyc($urandom_range(0, 3) != 0, enc(n), $urandom_range(0, 3) != 0, 0, a);
        end
        drain();

        // Reset mid-stream
        cyc(1, enc(20), 0, 0, a);
        cyc(1, enc(21), 0, 0, a);
        chk("pre_rst_ov", out_valid, 1);
        in_valid = 0;
        rst_n = 0; #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_B", B, 0);
        q.delete();
        m_have = 0;
        m_cnt  = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1; #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_ov", out_valid, 0);
        send(enc(10)); send(enc(50));
        drain();
        chk("post_rst_err_cnt", err_cnt, 1);

        // Clear coinciding with an S2 load
        m_have = 0;
        m_cnt  = 0;
        cyc(1, enc(77), 1, 0, a);
        cyc(0, 0, 0, 1, a);
        chk("clr_ld_ov", out_valid, 1);
        chk("clr_ld_B", B, 77);
        chk("clr_ld_dir", dir, 0);
        chk("clr_ld_step_err", step_err, 0);
        chk("clr_ld_err_cnt", err_cnt, 0);
        drain();
        send(enc(78));
        drain();
        chk("clr_next_dir", dir, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
